binary_add_chunked: RTL and testbench
=====================================

Name: binary_add_chunked

Overview:
Parametrised, multi-cycle binary adder/subtractor and the successor to the fixed 10-bit registered ripple adder. It adds or subtracts two WIDTH-bit operands CHUNK bits per cycle, least-significant chunk first, with the carry held in a register between chunks. Operands enter through a valid/ready handshake and results leave through one. Results are registered and include carry/borrow-out and signed overflow. It sits in the arithmetic datapath wherever a wide add must close timing at a high clock rate.

Parameters:
WIDTH, 32, operand and result width in bits; must be >= 2.
CHUNK, 8, bits processed per cycle; WIDTH must be an integer multiple of CHUNK.
NCHUNK, WIDTH/CHUNK, derived localparam; number of compute cycles.

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands; high only in IDLE
A  input  WIDTH  operand A
B  input  WIDTH  operand B
cin  input  1  carry-in (add) or borrow-in (sub)
sub  input  1  0 = A+B+cin, 1 = A-B-cin
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
S  output  WIDTH  result, registered
cout  output  1  add: carry-out; sub: borrow-out (1 = A < B+cin unsigned)
ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE, out_valid=0, S=0, cout=0, ovf=0.
  - Internal operand, partial-sum, carry and chunk-index registers are cleared.
  - in_ready=1 while rst_n is low and after release.
  - A reset during RUN or DONE aborts the operation; no result is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge T0:
    - capture A.
    - capture Beff = sub ? ~B : B.
    - capture carry0 = sub ? ~cin : cin.
    - capture sub into the mode register.
    - clear the chunk index k and go to RUN.
- RUN:
  - in_ready=0; in_valid is ignored.
  - Each cycle computes {c, sum[k*CHUNK +: CHUNK]} = A[chunk k] + Beff[chunk k] + carry, stores c into the carry register, and increments k.
  - Chunk k is committed at edge T0+1+k.
  - After chunk NCHUNK-1, go to DONE.
- DONE:
  - At edge T0+NCHUNK: S <= full sum; cout <= sub ? ~c_final : c_final.
  - At the same edge: ovf <= (A[MSB]==Beff[MSB]) && (sum[MSB]!=A[MSB]); out_valid <= 1.
  - Latency from input handshake to out_valid high is NCHUNK cycles.
  - S, cout and ovf stay stable while out_valid=1 && out_ready=0.
  - On out_valid&&out_ready: out_valid <= 0 and go to IDLE.
  - No input is accepted in the same cycle; minimum issue interval is NCHUNK+2 cycles.
  - S, cout and ovf hold their last values in IDLE and RUN until the next completion.
- Width rules:
  - All arithmetic is modulo 2^WIDTH.
  - Carry propagates across chunk boundaries only through the carry register.
  - NCHUNK=1 gives a single RUN cycle with latency 1.
- out_ready high before out_valid has no effect.
- Inputs are sampled only at the accept edge; later changes to A, B, cin or sub do not affect the result in flight.

Test Plan:
- Add, WIDTH=32, CHUNK=8: A=0xFFFFFFFF, B=0x00000001, cin=0, sub=0 -> S=0x00000000, cout=1, ovf=0. out_valid rises exactly 4 cycles after accept.
- Add, chunk-boundary carry: A=0x000000FF, B=0x00000001 -> S=0x00000100, cout=0. A=0x7FFFFFFF, B=1 -> S=0x80000000, ovf=1, cout=0.
- Sub: A=5, B=7, cin=0 -> S=0xFFFFFFFE, cout=1, ovf=0. A=0x80000000, B=1 -> S=0x7FFFFFFF, ovf=1, cout=0. A=9, B=4, cin=1 -> S=4, cout=0.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while pulsing in_valid with new operands -> S, cout and ovf unchanged, in_ready=0, new operands dropped. Release out_ready -> IDLE next cycle, in_ready=1.
- Reset mid-RUN: assert rst_n=0 after 2 chunks -> out_valid=0, S=0, cout=0, ovf=0 immediately. After release, in_ready=1 and a fresh add 3+4 gives S=7.
- WIDTH=10, CHUNK=10: A=0x3FF, B=0x001, cin=1 -> S=0x001, cout=1, latency 1. Same operands with WIDTH=10, CHUNK=5 -> same result, latency 2.

Source files
------------

// File: rtl/binary_add_chunked.sv
// binary_add_chunked
// Multi-cycle adder/subtractor. A WIDTH-bit add (or subtract) is performed
// CHUNK bits per clock, least-significant chunk first, with the inter-chunk
// carry kept in a register so the critical path is one CHUNK-bit adder.
// Subtraction is A + ~B + ~cin, so a single adder serves both modes.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready  operand handshake; in_ready is high only in IDLE
//   A, B, cin, sub      operands, carry/borrow-in, mode (0 add, 1 subtract)
//   out_valid, out_ready result handshake
//   S, cout, ovf        registered result, carry/borrow-out, signed overflow
module binary_add_chunked #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nxt;

  // Operand registers shift right one chunk per RUN cycle, so the chunk being
  // worked on is always in the low CHUNK bits. The partial sum fills from the
  // top and is fully aligned after NCHUNK shifts.
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;      // holds Beff (B or ~B)
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             mode_q;   // 1 = subtract; inverts the final carry into a borrow
  logic [KW-1:0]    k_q;

  logic             accept;
  logic             last_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] sum_nxt;

  assign accept     = in_valid && in_ready;
  assign last_chunk = (state == RUN) && (k_q == K_LAST);

  assign chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                   + (CHUNK+1)'(carry_q);
  assign sum_nxt   = (sum_q >> CHUNK)
                   | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of all others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (k_q == K_LAST) state_nxt = DONE;
      end
      DONE: begin
        // out_valid is always high in DONE, so out_ready alone completes it.
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the operand/sum registers are ordinary flops, not a memory array,
  // so they are cleared on reset along with the visible outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      mode_q    <= 1'b0;
      k_q       <= '0;
      S         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        a_q     <= A;
        b_q     <= sub ? ~B : B;
        carry_q <= sub ^ cin;     // sub ? ~cin : cin
        mode_q  <= sub;
        sum_q   <= '0;
        k_q     <= '0;
      end

      if (state == RUN) begin
        a_q     <= a_q >> CHUNK;
        b_q     <= b_q >> CHUNK;
        carry_q <= chunk_sum[CHUNK];
        sum_q   <= sum_nxt;
        k_q     <= k_q + 1'b1;
      end

      if (last_chunk) begin
        // On the last chunk the low CHUNK bits of a_q/b_q are the top chunk of
        // the operands, so bit CHUNK-1 is the operand MSB.
        S         <= sum_nxt;
        cout      <= mode_q ^ chunk_sum[CHUNK];
        ovf       <= (a_q[CHUNK-1] == b_q[CHUNK-1])
                  && (chunk_sum[CHUNK-1] != a_q[CHUNK-1]);
        out_valid <= 1'b1;
      end

      if ((state == DONE) && out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_binary_add_chunked.sv
// Bench for binary_add_chunked: three instances (32/8, 10/10, 10/5) share the
// input handshake and operands; each result is compared with an arithmetic
// reference model evaluated at that instance's width.
module tb_binary_add_chunked;

  localparam int BOUND = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  logic [2:0]  in_ready_v, out_valid_v, cout_v, ovf_v;
  logic [31:0] s32;
  logic [9:0]  s10a, s10b;
  logic [31:0] s_v [3];

  assign s_v[0] = s32;
  assign s_v[1] = {22'd0, s10a};
  assign s_v[2] = {22'd0, s10b};

  int wd [3] = '{32, 10, 10};
  int nc [3] = '{4, 1, 2};

  always #5 clk = ~clk;

  binary_add_chunked #(.WIDTH(32), .CHUNK(8)) u_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[0]),
    .A(a), .B(b), .cin(cin), .sub(sub),
    .out_valid(out_valid_v[0]), .out_ready(out_ready),
    .S(s32), .cout(cout_v[0]), .ovf(ovf_v[0])
  );

  binary_add_chunked #(.WIDTH(10), .CHUNK(10)) u_w10c10 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[1]),
    .A(a[9:0]), .B(b[9:0]), .cin(cin), .sub(sub),
    .out_valid(out_valid_v[1]), .out_ready(out_ready),
    .S(s10a), .cout(cout_v[1]), .ovf(ovf_v[1])
  );

  binary_add_chunked #(.WIDTH(10), .CHUNK(5)) u_w10c5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[2]),
    .A(a[9:0]), .B(b[9:0]), .cin(cin), .sub(sub),
    .out_valid(out_valid_v[2]), .out_ready(out_ready),
    .S(s10b), .cout(cout_v[2]), .ovf(ovf_v[2])
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] s;
    logic        cout;
    logic        ovf;
  } res_t;

  // Reference: plain integer arithmetic at width w, signed overflow judged by
  // whether the true signed result fits in w bits.
  function automatic res_t model(input int w, input logic [31:0] ta, input logic [31:0] tb,
                                 input logic tci, input logic tsb);
    res_t   r;
    longint m    = (longint'(1) << w) - 1;
    longint half = longint'(1) << (w - 1);
    longint ua   = longint'(ta) & m;
    longint ub   = longint'(tb) & m;
    longint sa   = (ua >= half) ? ua - (m + 1) : ua;
    longint sbv  = (ub >= half) ? ub - (m + 1) : ub;
    longint ci   = tci ? 1 : 0;
    longint u, sg;
    if (!tsb) begin
      u      = ua + ub + ci;
      sg     = sa + sbv + ci;
      r.cout = (u > m);
    end else begin
      u      = ua - ub - ci;
      sg     = sa - sbv - ci;
      r.cout = (ua < ub + ci);
    end
    r.s   = 32'(u & m);
    r.ovf = (sg >= half) || (sg < -half);
    return r;
  endfunction

  res_t exp_r [3];

  // Accept one transaction on all instances, wait for every out_valid, then
  // check latency and results. out_ready stays low, so results must hold.
  task automatic run_txn(input logic [31:0] ta, input logic [31:0] tb,
                         input logic tci, input logic tsb);
    int lat [3];
    @(negedge clk);
    check("in_ready before accept", 64'(in_ready_v), 64'h7);
    a = ta; b = tb; cin = tci; sub = tsb; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
    lat = '{0, 0, 0};
    for (int c = 1; c <= BOUND; c++) begin
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        if (out_valid_v[i] && lat[i] == 0) lat[i] = c;
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
    end
    for (int i = 0; i < 3; i++) begin
      exp_r[i] = model(wd[i], ta, tb, tci, tsb);
      check($sformatf("u%0d latency", i), 64'(lat[i]), 64'(nc[i]));
      check($sformatf("u%0d S %0h%s%0h", i, ta, tsb ? "-" : "+", tb), 64'(s_v[i]), 64'(exp_r[i].s));
      check($sformatf("u%0d cout", i), 64'(cout_v[i]), 64'(exp_r[i].cout));
      check($sformatf("u%0d ovf", i), 64'(ovf_v[i]), 64'(exp_r[i].ovf));
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid after release", 64'(out_valid_v), 64'h0);
    check("in_ready after release", 64'(in_ready_v), 64'h7);
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic        ci, sb;
    logic [31:0] es;
    logic        ec, eo;
  } vec_t;

  vec_t dirs [8] = '{
    '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0},
    '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0},
    '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1},
    '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1},
    '{32'h00000009, 32'h00000004, 1'b1, 1'b1, 32'h00000004, 1'b0, 1'b0},
    '{32'h000003FF, 32'h00000001, 1'b1, 1'b0, 32'h00000401, 1'b0, 1'b0},
    '{32'h00000003, 32'h00000004, 1'b0, 1'b0, 32'h00000007, 1'b0, 1'b0},
    '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b1, 1'b0}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("reset out_valid", 64'(out_valid_v), 64'h0);
    check("reset in_ready", 64'(in_ready_v), 64'h7);
    check("reset S", 64'(s32), 64'h0);
    check("reset cout/ovf", 64'({cout_v, ovf_v}), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with hand-derived 32-bit results.
    for (int d = 0; d < 8; d++) begin
      run_txn(dirs[d].a, dirs[d].b, dirs[d].ci, dirs[d].sb);
      check($sformatf("dir%0d S", d), 64'(s32), 64'(dirs[d].es));
      check($sformatf("dir%0d cout", d), 64'(cout_v[0]), 64'(dirs[d].ec));
      check($sformatf("dir%0d ovf", d), 64'(ovf_v[0]), 64'(dirs[d].eo));
      if (d == 5) begin
        check("w10c10 S 3ff+1+1", 64'(s10a), 64'h1);
        check("w10c10 cout 3ff+1+1", 64'(cout_v[1]), 64'h1);
        check("w10c5 S 3ff+1+1", 64'(s10b), 64'h1);
        check("w10c5 cout 3ff+1+1", 64'(cout_v[2]), 64'h1);
      end
      release_out();
    end

    // Backpressure: results hold and new operands are dropped.
    run_txn(32'h12345678, 32'h0F0F0F0F, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("bp in_ready", 64'(in_ready_v), 64'h0);
      check("bp out_valid", 64'(out_valid_v), 64'h7);
      for (int i = 0; i < 3; i++) begin
        check($sformatf("bp u%0d S", i), 64'(s_v[i]), 64'(exp_r[i].s));
        check($sformatf("bp u%0d cout/ovf", i), 64'({cout_v[i], ovf_v[i]}),
              64'({exp_r[i].cout, exp_r[i].ovf}));
      end
    end
    release_out();
    repeat (3) begin
      @(negedge clk);
      check("no dropped result", 64'(out_valid_v), 64'h0);
    end

    // Reset in the middle of RUN (after two chunks of the 32-bit instance).
    @(negedge clk);
    a = 32'hDEADBEEF; b = 32'h01234567; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst mid out_valid", 64'(out_valid_v), 64'h0);
    check("rst mid S", 64'({s32, s10a, s10b}), 64'h0);
    check("rst mid cout/ovf", 64'({cout_v, ovf_v}), 64'h0);
    check("rst mid in_ready", 64'(in_ready_v), 64'h7);
    #2;
    rst_n = 1'b1;
    run_txn(32'd3, 32'd4, 1'b0, 1'b0);
    check("post-reset 3+4", 64'(s32), 64'h7);
    release_out();

    // Random transactions against the model, biased toward boundary values.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (n % 5 == 0) ra = 32'hFFFFFFFF;
      if (n % 7 == 0) rb = 32'h80000000;
      run_txn(ra, rb, 1'($urandom), 1'($urandom));
      release_out();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
